// File: rtl/muldiv_ctrl_if.sv
// Multiply/divide controller bus: EX-stage request/response plus the external divider stream handshake.
interface muldiv_ctrl_if;
    logic [5:0]  md_op;
    logic        md_valid;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        ex_cancel;
    logic        md_stall;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        div_tvalid;
    logic        div_signed;
    logic [31:0] div_dividend;
    logic [31:0] div_divisor;
    logic        div_tready;
    logic        div_dout_tvalid;
    logic [63:0] div_dout_tdata;
    logic        div_err;

    modport master (
        output md_op, md_valid, src1, src2, ex_cancel,
        output div_tready, div_dout_tvalid, div_dout_tdata,
        input  md_stall, hi_out, lo_out, div_tvalid, div_signed,
        input  div_dividend, div_divisor, div_err
    );

    modport slave (
        input  md_op, md_valid, src1, src2, ex_cancel,
        input  div_tready, div_dout_tvalid, div_dout_tdata,
        output md_stall, hi_out, lo_out, div_tvalid, div_signed,
        output div_dividend, div_divisor, div_err
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// HI/LO owner: single-cycle mult/multu/mthi/mtlo, multi-cycle div/divu via external stream divider.
// Divides stall EX from launch until DONE; watchdog aborts a divider that never answers.
module muldiv_ctrl #(
    parameter int WDOG_CYCLES = 63
) (
    input  logic          clk,
    input  logic          reset,
    muldiv_ctrl_if.slave  bus
);
    localparam int CW = ($clog2(WDOG_CYCLES + 1) > 6) ? $clog2(WDOG_CYCLES + 1) : 6;
    localparam logic [CW-1:0] WDOG_MAX = CW'(WDOG_CYCLES);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_FLUSH} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] wdog_cnt;
    logic [31:0]   hi_q, lo_q, dividend_q, divisor_q;
    logic [63:0]   res_q;
    logic          signed_q, err_q;
    logic          tvalid, stall, abort;
    logic          accept, launch, wdog_hit;
    logic [63:0]   prod_s, prod_u;

    // Multi-hot opcodes are NOPs: never accepted, never launch.
    assign accept   = (state == S_IDLE) && bus.md_valid && $onehot(bus.md_op) && !bus.ex_cancel;
    assign launch   = accept && (bus.md_op[2] || bus.md_op[3]);
    assign wdog_hit = (wdog_cnt == WDOG_MAX);

    assign prod_s = $signed({{32{bus.src1[31]}}, bus.src1}) * $signed({{32{bus.src2[31]}}, bus.src2});
    assign prod_u = {32'd0, bus.src1} * {32'd0, bus.src2};

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        tvalid    = 1'b0;
        stall     = 1'b0;
        abort     = 1'b0;
        case (state)
            S_IDLE: begin
                if (launch) begin
                    stall     = 1'b1;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                tvalid = 1'b1;
                stall  = 1'b1;
                if (bus.ex_cancel) begin
                    // Once the divider has taken the operands its answer must still be drained.
                    if (bus.div_tready) begin
                        state_nxt = S_FLUSH;
                    end else begin
                        state_nxt = S_IDLE;
                        stall     = 1'b0;
                    end
                end else if (bus.div_tready) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                stall = 1'b1;
                if (bus.div_dout_tvalid) begin
                    state_nxt = bus.ex_cancel ? S_IDLE : S_DONE;
                end else if (bus.ex_cancel) begin
                    state_nxt = S_FLUSH;
                end else if (wdog_hit) begin
                    state_nxt = S_IDLE;
                    abort     = 1'b1;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            S_FLUSH: begin
                stall = 1'b1;
                if (bus.div_dout_tvalid) begin
                    state_nxt = S_IDLE;
                end else if (wdog_hit) begin
                    state_nxt = S_IDLE;
                    abort     = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wdog_cnt <= '0;
        end else if ((state_nxt == S_WAIT && state != S_WAIT) ||
                     (state_nxt == S_FLUSH && state != S_FLUSH)) begin
            wdog_cnt <= '0;
        end else if ((state == S_WAIT || state == S_FLUSH) && !wdog_hit) begin
            wdog_cnt <= wdog_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q       <= '0;
            lo_q       <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            signed_q   <= 1'b0;
            res_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            err_q <= abort;
            if (accept) begin
                case (bus.md_op)
                    6'b000001: {hi_q, lo_q} <= prod_s;
                    6'b000010: {hi_q, lo_q} <= prod_u;
                    6'b010000: hi_q <= bus.src1;
                    6'b100000: lo_q <= bus.src1;
                    default: ;
                endcase
            end
            if (launch) begin
                dividend_q <= bus.src1;
                divisor_q  <= bus.src2;
                signed_q   <= bus.md_op[2];
            end
            if (state == S_WAIT && bus.div_dout_tvalid) res_q <= bus.div_dout_tdata;
            if (state == S_DONE && !bus.ex_cancel) begin
                hi_q <= res_q[31:0];
                lo_q <= res_q[63:32];
            end
        end
    end

    assign bus.md_stall     = stall;
    assign bus.hi_out       = hi_q;
    assign bus.lo_out       = lo_q;
    assign bus.div_tvalid   = tvalid;
    assign bus.div_signed   = signed_q;
    assign bus.div_dividend = dividend_q;
    assign bus.div_divisor  = divisor_q;
    assign bus.div_err      = err_q;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: mult/mt*, div paths, cancel, watchdog and reset recovery.
module tb_muldiv_ctrl;
    localparam int WDOG = 63;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    muldiv_ctrl_if bus();

    muldiv_ctrl #(.WDOG_CYCLES(WDOG)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.md_op = '0; bus.md_valid = 0; bus.src1 = '0; bus.src2 = '0; bus.ex_cancel = 0;
        bus.div_tready = 0; bus.div_dout_tvalid = 0; bus.div_dout_tdata = '0;
        reset = 1; tick(); tick(); reset = 0; #1;
        checks++; if (bus.hi_out !== 32'h0) begin errors++; $display("FAIL reset_hi got %h want 0", bus.hi_out); end
        checks++; if (bus.lo_out !== 32'h0) begin errors++; $display("FAIL reset_lo got %h want 0", bus.lo_out); end
        checks++; if (bus.md_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", bus.md_stall); end
        checks++; if (bus.div_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b want 0", bus.div_tvalid); end
        checks++; if (bus.div_signed !== 1'b0) begin errors++; $display("FAIL reset_signed got %b want 0", bus.div_signed); end
        checks++; if (bus.div_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", bus.div_err); end
    endtask

    task automatic test_mult();
        bus.md_op = 6'b000001; bus.md_valid = 1; bus.src1 = 32'hFFFFFFFE; bus.src2 = 32'd3; #1;
        checks++; if (bus.md_stall !== 1'b0) begin errors++; $display("FAIL mult_stall got %b want 0", bus.md_stall); end
        tick();
        checks++; if (bus.hi_out !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi got %h want ffffffff", bus.hi_out); end
        checks++; if (bus.lo_out !== 32'hFFFFFFFA) begin errors++; $display("FAIL mult_lo got %h want fffffffa", bus.lo_out); end
        bus.md_op = 6'b000010; #1;
        checks++; if (bus.md_stall !== 1'b0) begin errors++; $display("FAIL multu_stall got %b want 0", bus.md_stall); end
        tick();
        checks++; if (bus.hi_out !== 32'h00000002) begin errors++; $display("FAIL multu_hi got %h want 00000002", bus.hi_out); end
        checks++; if (bus.lo_out !== 32'hFFFFFFFA) begin errors++; $display("FAIL multu_lo got %h want fffffffa", bus.lo_out); end
        // Cancelled mult must leave HI/LO alone.
        bus.md_op = 6'b000001; bus.src1 = 32'd5; bus.src2 = 32'd5; bus.ex_cancel = 1;
        tick();
        checks++; if (bus.lo_out !== 32'hFFFFFFFA) begin errors++; $display("FAIL mult_cancel_lo got %h want fffffffa", bus.lo_out); end
        bus.ex_cancel = 0; bus.md_valid = 0;
    endtask

    task automatic test_move();
        bus.md_op = 6'b010000; bus.md_valid = 1; bus.src1 = 32'h12345678; bus.ex_cancel = 1;
        tick();
        checks++; if (bus.hi_out !== 32'h00000002) begin errors++; $display("FAIL mthi_cancel_hi got %h want 00000002", bus.hi_out); end
        bus.ex_cancel = 0;
        tick();
        checks++; if (bus.hi_out !== 32'h12345678) begin errors++; $display("FAIL mthi_hi got %h want 12345678", bus.hi_out); end
        checks++; if (bus.lo_out !== 32'hFFFFFFFA) begin errors++; $display("FAIL mthi_lo got %h want fffffffa", bus.lo_out); end
        bus.md_op = 6'b100000; bus.src1 = 32'hCAFEF00D;
        tick();
        checks++; if (bus.lo_out !== 32'hCAFEF00D) begin errors++; $display("FAIL mtlo_lo got %h want cafef00d", bus.lo_out); end
        checks++; if (bus.hi_out !== 32'h12345678) begin errors++; $display("FAIL mtlo_hi got %h want 12345678", bus.hi_out); end
        // Two opcode bits set is a NOP.
        bus.md_op = 6'b010100; bus.src1 = 32'h0BADF00D; #1;
        checks++; if (bus.md_stall !== 1'b0) begin errors++; $display("FAIL nop_stall got %b want 0", bus.md_stall); end
        tick();
        checks++; if (bus.hi_out !== 32'h12345678) begin errors++; $display("FAIL nop_hi got %h want 12345678", bus.hi_out); end
        checks++; if (bus.div_tvalid !== 1'b0) begin errors++; $display("FAIL nop_tvalid got %b want 0", bus.div_tvalid); end
        bus.md_valid = 0;
    endtask

    task automatic test_div();
        bus.md_op = 6'b000100; bus.md_valid = 1; bus.src1 = 32'hFFFFFFF9; bus.src2 = 32'd2; #1;
        checks++; if (bus.md_stall !== 1'b1) begin errors++; $display("FAIL div_launch_stall got %b want 1", bus.md_stall); end
        checks++; if (bus.div_tvalid !== 1'b0) begin errors++; $display("FAIL div_launch_tvalid got %b want 0", bus.div_tvalid); end
        tick();
        for (int i = 0; i < 3; i++) begin
            bus.div_tready = (i == 2);
            if (i == 1) bus.src1 = 32'h0;
            #1;
            checks++; if (bus.div_tvalid !== 1'b1) begin errors++; $display("FAIL div_issue_tvalid[%0d] got %b want 1", i, bus.div_tvalid); end
            checks++; if (bus.md_stall !== 1'b1) begin errors++; $display("FAIL div_issue_stall[%0d] got %b want 1", i, bus.md_stall); end
            checks++; if (bus.div_dividend !== 32'hFFFFFFF9) begin errors++; $display("FAIL div_dividend[%0d] got %h want fffffff9", i, bus.div_dividend); end
            tick();
        end
        checks++; if (bus.div_signed !== 1'b1) begin errors++; $display("FAIL div_signed got %b want 1", bus.div_signed); end
        checks++; if (bus.div_divisor !== 32'd2) begin errors++; $display("FAIL div_divisor got %h want 2", bus.div_divisor); end
        bus.div_tready = 0;
        for (int i = 0; i < 9; i++) begin
            #1;
            checks++; if (bus.div_tvalid !== 1'b0) begin errors++; $display("FAIL div_wait_tvalid[%0d] got %b want 0", i, bus.div_tvalid); end
            checks++; if (bus.md_stall !== 1'b1) begin errors++; $display("FAIL div_wait_stall[%0d] got %b want 1", i, bus.md_stall); end
            tick();
        end
        bus.div_dout_tvalid = 1; bus.div_dout_tdata = {32'hFFFFFFFD, 32'hFFFFFFFF}; #1;
        checks++; if (bus.md_stall !== 1'b1) begin errors++; $display("FAIL div_dout_stall got %b want 1", bus.md_stall); end
        tick();
        bus.div_dout_tvalid = 0; #1;
        checks++; if (bus.md_stall !== 1'b0) begin errors++; $display("FAIL div_done_stall got %b want 0", bus.md_stall); end
        bus.md_valid = 0;
        tick();
        checks++; if (bus.hi_out !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_hi got %h want ffffffff", bus.hi_out); end
        checks++; if (bus.lo_out !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_lo got %h want fffffffd", bus.lo_out); end
        checks++; if (bus.md_stall !== 1'b0) begin errors++; $display("FAIL div_idle_stall got %b want 0", bus.md_stall); end
    endtask

    task automatic test_div_flush();
        bus.md_op = 6'b001000; bus.md_valid = 1; bus.src1 = 32'd100; bus.src2 = 32'd7; bus.div_tready = 1;
        tick();
        checks++; if (bus.div_signed !== 1'b0) begin errors++; $display("FAIL divu_signed got %b want 0", bus.div_signed); end
        tick();
        bus.div_tready = 0; bus.ex_cancel = 1; #1;
        checks++; if (bus.md_stall !== 1'b1) begin errors++; $display("FAIL flush_cancel_stall got %b want 1", bus.md_stall); end
        tick();
        bus.ex_cancel = 0; bus.md_valid = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus.md_stall !== 1'b1) begin errors++; $display("FAIL flush_stall[%0d] got %b want 1", i, bus.md_stall); end
            tick();
        end
        bus.div_dout_tvalid = 1; bus.div_dout_tdata = {32'd14, 32'd2}; #1;
        checks++; if (bus.md_stall !== 1'b1) begin errors++; $display("FAIL flush_dout_stall got %b want 1", bus.md_stall); end
        tick();
        bus.div_dout_tvalid = 0; #1;
        checks++; if (bus.md_stall !== 1'b0) begin errors++; $display("FAIL flush_after_stall got %b want 0", bus.md_stall); end
        tick();
        checks++; if (bus.hi_out !== 32'hFFFFFFFF) begin errors++; $display("FAIL flush_hi got %h want ffffffff", bus.hi_out); end
        checks++; if (bus.lo_out !== 32'hFFFFFFFD) begin errors++; $display("FAIL flush_lo got %h want fffffffd", bus.lo_out); end
    endtask

    task automatic test_issue_cancel();
        bus.md_op = 6'b000100; bus.md_valid = 1; bus.src1 = 32'd9; bus.src2 = 32'd3; bus.div_tready = 0;
        tick();
        bus.ex_cancel = 1; #1;
        checks++; if (bus.div_tvalid !== 1'b1) begin errors++; $display("FAIL icancel_tvalid got %b want 1", bus.div_tvalid); end
        checks++; if (bus.md_stall !== 1'b0) begin errors++; $display("FAIL icancel_stall got %b want 0", bus.md_stall); end
        tick();
        bus.ex_cancel = 0; bus.md_valid = 0; #1;
        checks++; if (bus.div_tvalid !== 1'b0) begin errors++; $display("FAIL icancel_drop_tvalid got %b want 0", bus.div_tvalid); end
        tick();
        checks++; if (bus.hi_out !== 32'hFFFFFFFF) begin errors++; $display("FAIL icancel_hi got %h want ffffffff", bus.hi_out); end
    endtask

    task automatic test_watchdog();
        bus.md_op = 6'b000100; bus.md_valid = 1; bus.src1 = 32'd50; bus.src2 = 32'd5; bus.div_tready = 1;
        tick(); tick();
        bus.div_tready = 0; bus.md_op = 6'b100000; bus.src1 = 32'hBAD0BAD0;
        for (int i = 0; i <= WDOG; i++) begin
            if (i == WDOG) bus.md_valid = 0;
            #1;
            checks++; if (bus.div_err !== 1'b0) begin errors++; $display("FAIL wdog_early_err[%0d] got %b want 0", i, bus.div_err); end
            checks++; if (bus.md_stall !== 1'b1) begin errors++; $display("FAIL wdog_stall[%0d] got %b want 1", i, bus.md_stall); end
            tick();
        end
        checks++; if (bus.div_err !== 1'b1) begin errors++; $display("FAIL wdog_err got %b want 1", bus.div_err); end
        checks++; if (bus.md_stall !== 1'b0) begin errors++; $display("FAIL wdog_idle_stall got %b want 0", bus.md_stall); end
        checks++; if (bus.lo_out !== 32'hFFFFFFFD) begin errors++; $display("FAIL wdog_lo got %h want fffffffd", bus.lo_out); end
        tick();
        checks++; if (bus.div_err !== 1'b0) begin errors++; $display("FAIL wdog_err_pulse got %b want 0", bus.div_err); end
        bus.div_dout_tvalid = 1; bus.div_dout_tdata = {32'd10, 32'd0};
        tick(); tick();
        bus.div_dout_tvalid = 0;
        checks++; if (bus.hi_out !== 32'hFFFFFFFF) begin errors++; $display("FAIL wdog_late_hi got %h want ffffffff", bus.hi_out); end
    endtask

    task automatic test_reset_mid();
        bus.md_op = 6'b000100; bus.md_valid = 1; bus.src1 = 32'd81; bus.src2 = 32'd9; bus.div_tready = 1;
        tick(); tick();
        bus.div_tready = 0;
        tick(); tick();
        reset = 1; bus.md_valid = 0;
        tick();
        reset = 0;
        checks++; if (bus.hi_out !== 32'h0) begin errors++; $display("FAIL rmid_hi got %h want 0", bus.hi_out); end
        checks++; if (bus.md_stall !== 1'b0) begin errors++; $display("FAIL rmid_stall got %b want 0", bus.md_stall); end
        checks++; if (bus.div_signed !== 1'b0) begin errors++; $display("FAIL rmid_signed got %b want 0", bus.div_signed); end
        bus.div_dout_tvalid = 1; bus.div_dout_tdata = {32'd9, 32'd0};
        tick(); tick();
        bus.div_dout_tvalid = 0; tick();
        checks++; if (bus.hi_out !== 32'h0) begin errors++; $display("FAIL rmid_late_hi got %h want 0", bus.hi_out); end
        checks++; if (bus.lo_out !== 32'h0) begin errors++; $display("FAIL rmid_late_lo got %h want 0", bus.lo_out); end
        checks++; if (bus.md_stall !== 1'b0) begin errors++; $display("FAIL rmid_late_stall got %b want 0", bus.md_stall); end
        checks++; if (bus.div_tvalid !== 1'b0) begin errors++; $display("FAIL rmid_late_tvalid got %b want 0", bus.div_tvalid); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_move();
        test_div();
        test_div_flush();
        test_issue_cancel();
        test_watchdog();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
